// File: rtl/pupil_locate.sv
// pupil_locate -- bounding box, pixel count and centre of the foreground in a
// raster-order binary-mask frame.
//
// Build option: define PUPIL_CENTROID_EN to compute the centre as the mean
// foreground coordinate (two 17-cycle restoring dividers). Without it the
// centre is the bounding-box midpoint and CALC lasts one cycle.
//
// Ports:
//   clock        rising-edge clock
//   rst          asynchronous active-high reset
//   data_valid   pixel present on data_in this cycle
//   data_in      mask pixel; non-zero marks foreground
//   busy         high in CALC/DONE; pixels offered then are dropped
//   result_valid one-cycle pulse when the result registers load
//   found        last frame held at least one foreground pixel
//   x_min/x_max  column bounds; y_min/y_max row bounds
//   center_x/y   pupil centre
//   pix_count    foreground pixel count of the last frame
//   overrun      sticky, set when a pixel is dropped while busy
module pupil_locate #(
  parameter int data_width = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [data_width-1:0] data_in,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  found,
  output logic [8:0]            x_min,
  output logic [8:0]            x_max,
  output logic [7:0]            y_min,
  output logic [7:0]            y_max,
  output logic [8:0]            center_x,
  output logic [7:0]            center_y,
  output logic [16:0]           pix_count,
  output logic                  overrun
);

  localparam logic [8:0] LAST_COL = 9'(IMG_WIDTH - 1);
  localparam logic [7:0] LAST_ROW = 8'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {ACCUM, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [8:0]  col;
  logic [7:0]  row;
  logic [8:0]  acc_xmin, acc_xmax;
  logic [7:0]  acc_ymin, acc_ymax;
  logic [16:0] acc_cnt;
  logic        take, fg, last_pix, calc_done;

  assign busy     = (state != ACCUM);
  assign take     = data_valid && (state == ACCUM);
  assign fg       = take && (data_in != '0);
  assign last_pix = take && (col == LAST_COL) && (row == LAST_ROW);

`ifdef PUPIL_CENTROID_EN
  logic [25:0] acc_sx;
  logic [24:0] acc_sy;
  logic [4:0]  step;
  logic [16:0] rem_x, quo_x, rem_y, quo_y;
  logic [16:0] src_rem_x, src_q_x, src_rem_y, src_q_y;
  logic [17:0] sh_x, sh_y;
  logic        ge_x, ge_y;

  assign calc_done = (step == 5'd16);

  // The mean coordinate is below 2^9, so the top dividend bits are already
  // smaller than the divisor: seeding the remainder with them leaves exactly
  // 17 quotient bits to resolve, one per CALC cycle.
  always_comb begin
    src_rem_x = (step == 5'd0) ? {8'd0, acc_sx[25:17]} : rem_x;
    src_q_x   = (step == 5'd0) ? acc_sx[16:0] : quo_x;
    src_rem_y = (step == 5'd0) ? {9'd0, acc_sy[24:17]} : rem_y;
    src_q_y   = (step == 5'd0) ? {acc_sy[16:0]} : quo_y;
    sh_x      = {src_rem_x, src_q_x[16]};
    sh_y      = {src_rem_y, src_q_y[16]};
    ge_x      = (sh_x >= {1'b0, acc_cnt});
    ge_y      = (sh_y >= {1'b0, acc_cnt});
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      step  <= '0;
      rem_x <= '0;
      quo_x <= '0;
      rem_y <= '0;
      quo_y <= '0;
    end else if (state == CALC) begin
      step  <= step + 5'd1;
      rem_x <= ge_x ? 17'(sh_x - {1'b0, acc_cnt}) : sh_x[16:0];
      rem_y <= ge_y ? 17'(sh_y - {1'b0, acc_cnt}) : sh_y[16:0];
      quo_x <= {src_q_x[15:0], ge_x};
      quo_y <= {src_q_y[15:0], ge_y};
    end else begin
      step <= '0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      acc_sx <= '0;
      acc_sy <= '0;
    end else if (state == DONE) begin
      acc_sx <= '0;
      acc_sy <= '0;
    end else if (fg) begin
      acc_sx <= acc_sx + {17'd0, col};
      acc_sy <= acc_sy + {17'd0, row};
    end
  end
`else
  assign calc_done = 1'b1;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_pix) state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = DONE;
      DONE:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst || 1'b0) begin
      col      <= '0;
      row      <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (state == DONE) begin
      col      <= '0;
      row      <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (take) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 9'd1;
      end
      if (fg) begin
        if (col < acc_xmin) acc_xmin <= col;
        if (col > acc_xmax) acc_xmax <= col;
        if (row < acc_ymin) acc_ymin <= row;
        if (row > acc_ymax) acc_ymax <= row;
        acc_cnt <= acc_cnt + 17'd1;
      end
    end
  end

  // Results load on the edge that leaves DONE; result_valid marks that edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      found        <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      center_x     <= '0;
      center_y     <= '0;
      pix_count    <= '0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      if (data_valid && busy) overrun <= 1'b1;
      if (state == DONE) begin
        pix_count <= acc_cnt;
        if (acc_cnt == '0) begin
          found    <= 1'b0;
          x_min    <= '0;
          x_max    <= '0;
          y_min    <= '0;
          y_max    <= '0;
          center_x <= '0;
          center_y <= '0;
        end else begin
          found <= 1'b1;
          x_min <= acc_xmin;
          x_max <= acc_xmax;
          y_min <= acc_ymin;
          y_max <= acc_ymax;
`ifdef PUPIL_CENTROID_EN
          center_x <= quo_x[8:0];
          center_y <= quo_y[7:0];
`else
          center_x <= 9'(({1'b0, acc_xmin} + {1'b0, acc_xmax}) >> 1);
          center_y <= 8'(({1'b0, acc_ymin} + {1'b0, acc_ymax}) >> 1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pupil_locate.sv
// tb_pupil_locate -- self-checking bench for pupil_locate.
// The DUT is built with a reduced 112x64 frame so that several complete
// frames fit in a short run; the directed coordinates are placed to exercise
// the same edges (last column/row, interior block, origin).
// Define PUPIL_CENTROID_EN for both files to check the centroid build.
module tb_pupil_locate;
  localparam int W = 112;
  localparam int H = 64;
`ifdef PUPIL_CENTROID_EN
  localparam int LAT      = 18;
  localparam bit CENTROID = 1'b1;
`else
  localparam int LAT      = 2;
  localparam bit CENTROID = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst, data_valid;
  logic [7:0]  data_in;
  logic        busy, result_valid, found, overrun;
  logic [8:0]  x_min, x_max, center_x;
  logic [7:0]  y_min, y_max, center_y;
  logic [16:0] pix_count;

  pupil_locate #(.data_width(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .busy(busy), .result_valid(result_valid), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .center_x(center_x), .center_y(center_y), .pix_count(pix_count),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit overrun_exp = 1'b0;
  bit img [H][W];

  typedef struct {
    int x0, x1, y0, y1;      // filled rectangle (x0>x1 means none)
    int p1x, p1y, p2x, p2y;  // extra single pixels (-1 means none)
    bit inject;              // offer pixels while busy
    bit e_found;
    int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_cx, e_cy;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'b0;
  endtask

  task automatic paint(input int x0, input int x1, input int y0, input int y1);
    for (int r = y0; r <= y1; r++)
      for (int c = x0; c <= x1; c++) img[r][c] = 1'b1;
  endtask

  // Sends pixels in raster order with occasional idle cycles; stops after
  // stop_pix pixels when stop_pix >= 0.
  task automatic stream(input int stop_pix);
    int n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (stop_pix >= 0 && n == stop_pix) return;
        if ($urandom_range(0, 15) == 0) begin
          @(negedge clock);
          data_valid = 1'b0;
          data_in    = 8'($urandom_range(1, 255));
        end
        @(negedge clock);
        data_valid = 1'b1;
        data_in    = img[r][c] ? 8'($urandom_range(1, 255)) : 8'h00;
        n++;
      end
  endtask

  // Called right after the last pixel has been driven. Index i counts the
  // negedges after the edge that sampled that pixel.
  task automatic wait_result(input bit inject, input string tag);
    int lat = -1;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (i == 0) chk({tag, ".busy"}, int'(busy), 1);
      if (lat >= 0) begin
        chk({tag, ".pulse_width"}, int'(result_valid), 0);
        done = 1'b1;
      end else if (result_valid === 1'b1) begin
        lat = i;
      end
      data_valid = inject && (i < LAT);
      data_in    = 8'hFF;
    end
    if (inject) overrun_exp = 1'b1;
    chk({tag, ".latency"}, lat, LAT);
  endtask

  task automatic check_frame(input string tag, input bit ef, input int xmn,
                             input int xmx, input int ymn, input int ymx,
                             input int cnt, input int cx, input int cy);
    chk({tag, ".found"},     int'(found),     int'(ef));
    chk({tag, ".x_min"},     int'(x_min),     xmn);
    chk({tag, ".x_max"},     int'(x_max),     xmx);
    chk({tag, ".y_min"},     int'(y_min),     ymn);
    chk({tag, ".y_max"},     int'(y_max),     ymx);
    chk({tag, ".pix_count"}, int'(pix_count), cnt);
    chk({tag, ".center_x"},  int'(center_x),  cx);
    chk({tag, ".center_y"},  int'(center_y),  cy);
    chk({tag, ".overrun"},   int'(overrun),   int'(overrun_exp));
  endtask

  // Reference: scan the painted image directly.
  task automatic model(output bit ef, output int xmn, output int xmx,
                       output int ymn, output int ymx, output int cnt,
                       output int cx, output int cy);
    longint sx = 0, sy = 0;
    xmn = W; xmx = -1; ymn = H; ymx = -1; cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r][c]) begin
          cnt++;
          sx += c;
          sy += r;
          if (c < xmn) xmn = c;
          if (c > xmx) xmx = c;
          if (r < ymn) ymn = r;
          if (r > ymx) ymx = r;
        end
    ef = (cnt != 0);
    if (cnt == 0) begin
      xmn = 0; xmx = 0; ymn = 0; ymx = 0; cx = 0; cy = 0;
    end else if (CENTROID) begin
      cx = int'(sx / cnt);
      cy = int'(sy / cnt);
    end else begin
      cx = (xmn + xmx) / 2;
      cy = (ymn + ymx) / 2;
    end
  endtask

  task automatic random_img(input int min_rects);
    int n;
    clear_img();
    n = $urandom_range(min_rects, 3);
    for (int k = 0; k < n; k++) begin
      int x0, y0, x1, y1;
      x0 = $urandom_range(0, W - 1);
      y0 = $urandom_range(0, H - 1);
      x1 = $urandom_range(x0, (x0 + 20 < W) ? x0 + 20 : W - 1);
      y1 = $urandom_range(y0, (y0 + 12 < H) ? y0 + 12 : H - 1);
      paint(x0, x1, y0, y1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},         int'(busy),         0);
    chk({tag, ".result_valid"}, int'(result_valid), 0);
    chk({tag, ".found"},        int'(found),        0);
    chk({tag, ".bounds"},       int'({x_min, x_max, y_min, y_max} != '0), 0);
    chk({tag, ".center"},       int'({center_x, center_y} != '0), 0);
    chk({tag, ".pix_count"},    int'(pix_count),    0);
    chk({tag, ".overrun"},      int'(overrun),      0);
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ef;
    int xmn, xmx, ymn, ymx, cnt, cx, cy, seen;

    //          rect             extra pixels   inj  found xmin xmax ymin ymax cnt  cx                 cy
    vecs[0] = '{1, 0, 0, 0,      -1, -1, -1, -1, 0,  0,    0,   0,   0,   0,   0,   0,                 0};
    vecs[1] = '{100, 109, 50, 59, -1, -1, -1, -1, 0, 1,    100, 109, 50,  59,  100, 104,               54};
    vecs[2] = '{W-1, W-1, H-1, H-1, -1, -1, -1, -1, 1, 1,  W-1, W-1, H-1, H-1, 1,   W-1,               H-1};
    vecs[3] = '{0, 0, 0, 0,       3, 0, 3, 3,    0,  1,    0,   3,   0,   3,   3,   CENTROID ? 2 : 1,  1};

    rst = 1'b1;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      clear_img();
      if (vecs[v].x0 <= vecs[v].x1) paint(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1);
      if (vecs[v].p1x >= 0) img[vecs[v].p1y][vecs[v].p1x] = 1'b1;
      if (vecs[v].p2x >= 0) img[vecs[v].p2y][vecs[v].p2x] = 1'b1;
      stream(-1);
      wait_result(vecs[v].inject, tag);
      check_frame(tag, vecs[v].e_found, vecs[v].e_xmin, vecs[v].e_xmax,
                  vecs[v].e_ymin, vecs[v].e_ymax, vecs[v].e_cnt,
                  vecs[v].e_cx, vecs[v].e_cy);
    end

    // Random frame against the reference model.
    random_img(1);
    model(ef, xmn, xmx, ymn, ymx, cnt, cx, cy);
    stream(-1);
    wait_result(1'b0, "rand");
    check_frame("rand", ef, xmn, xmx, ymn, ymx, cnt, cx, cy);

    // Reset while in CALC: no result may appear, outputs stay cleared.
    random_img(1);
    stream(-1);
    @(negedge clock);
    chk("calc_rst.busy_before", int'(busy), 1);
    rst = 1'b1;
    data_valid = 1'b0;
    overrun_exp = 1'b0;
    #1;
    check_all_zero("calc_rst");
    @(negedge clock);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (result_valid === 1'b1) seen = 1;
    end
    chk("calc_rst.no_result", seen, 0);

    // Reset part way through row 32, then a frame with only (5,5).
    random_img(2);
    stream(32 * W + 10);
    @(negedge clock);
    rst = 1'b1;
    data_valid = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clock);
    rst = 1'b0;
    clear_img();
    img[5][5] = 1'b1;
    stream(-1);
    wait_result(1'b0, "after_rst");
    check_frame("after_rst", 1'b1, 5, 5, 5, 5, 1, 5, 5);

    // Outputs hold between pulses.
    repeat (5) @(negedge clock);
    chk("hold.pix_count", int'(pix_count), 1);
    chk("hold.center_x", int'(center_x), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
